// File: rtl/bids_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// bids_ctrl_sequencer
//   Command sequencer in front of the bid controller. Host commands are queued
//   in a small FIFO and executed one at a time. A single op is driven onto the
//   controller's op/data port for one cycle. A round holds C_start high for N
//   cycles and then waits (bounded) for roundOver. Each command produces
//   exactly one registered response.
//
// Ports
//   clk, reset_n         clock, synchronous active-low reset
//   cmd_valid/ready      host command handshake (ready = queue not full)
//   cmd_kind             0 = single op, 1 = round
//   cmd_op, cmd_data     opcode/data (op) or round length in data[15:0] (round)
//   C_op, C_data,        controller control port
//   C_start
//   ctrl_ready           controller may accept a new command
//   ctrl_err             controller error (combinational from C_op/C_data)
//   ctrl_roundOver       controller round finished
//   ctrl_win             {X_win, Y_win, Z_win}
//   ctrl_maxBid          winning bid
//   rsp_valid            one-cycle response strobe
//   rsp_kind/err/win/    registered response fields, held until next response
//   rsp_maxbid/timeout
//   busy                 sequencer not idle
//   fifo_count           queued entries
// -----------------------------------------------------------------------------
module bids_ctrl_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned ROUND_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_kind,
  input  logic [3:0]                    cmd_op,
  input  logic [31:0]                   cmd_data,
  output logic [3:0]                    C_op,
  output logic [31:0]                   C_data,
  output logic                          C_start,
  input  logic                          ctrl_ready,
  input  logic [2:0]                    ctrl_err,
  input  logic                          ctrl_roundOver,
  input  logic [2:0]                    ctrl_win,
  input  logic [31:0]                   ctrl_maxBid,
  output logic                          rsp_valid,
  output logic                          rsp_kind,
  output logic [2:0]                    rsp_err,
  output logic [2:0]                    rsp_win,
  output logic [31:0]                   rsp_maxbid,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(ROUND_TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_ROUND  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_REPORT = 3'd4;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOCK = 4'd2;

  // Command queue storage (no reset needed; validity tracked by r_count)
  logic          r_fifo_kind [FIFO_DEPTH];
  logic [3:0]    r_fifo_op   [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rdy_en;

  logic [2:0]    r_state;
  logic [3:0]    r_op;
  logic [31:0]   r_data;
  logic [15:0]   r_rcnt;
  logic [TW-1:0] r_to;

  logic          r_rsp_kind;
  logic [2:0]    r_rsp_err;
  logic [2:0]    r_rsp_win;
  logic [31:0]   r_rsp_maxbid;
  logic          r_rsp_timeout;

  logic          w_push;
  logic          w_pop;
  logic          w_head_kind;
  logic [3:0]    w_head_op;
  logic [31:0]   w_head_data;

  // r_rdy_en keeps cmd_ready low during reset and for the reset-sampling cycle
  assign cmd_ready   = r_rdy_en && (r_count < CW'(FIFO_DEPTH));
  assign w_push      = cmd_valid && cmd_ready;
  assign w_pop       = (r_state == ST_IDLE) && (r_count != '0) && ctrl_ready;
  assign w_head_kind = r_fifo_kind[r_rd_ptr];
  assign w_head_op   = r_fifo_op[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_kind[r_wr_ptr] <= cmd_kind;
      r_fifo_op[r_wr_ptr]   <= cmd_op;
      r_fifo_data[r_wr_ptr] <= cmd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_data        <= '0;
      r_rcnt        <= '0;
      r_to          <= '0;
      r_rsp_kind    <= 1'b0;
      r_rsp_err     <= '0;
      r_rsp_win     <= '0;
      r_rsp_maxbid  <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_op   <= w_head_op;
            r_data <= w_head_data;
            // A zero-length round still runs for one cycle
            r_rcnt <= (w_head_data[15:0] == 16'd0) ? 16'd1 : w_head_data[15:0];
            r_state <= w_head_kind ? ST_ROUND : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_rsp_kind    <= 1'b0;
          r_rsp_err     <= ctrl_err;
          r_rsp_win     <= '0;
          r_rsp_maxbid  <= '0;
          r_rsp_timeout <= 1'b0;
          r_state       <= ST_REPORT;
        end
        ST_ROUND: begin
          if (r_rcnt == 16'd1) begin
            r_to    <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
        ST_WAIT: begin
          // roundOver wins over an expiring timeout in the same cycle
          if (ctrl_roundOver) begin
            r_rsp_kind    <= 1'b1;
            r_rsp_err     <= ctrl_err;
            r_rsp_win     <= ctrl_win;
            r_rsp_maxbid  <= ctrl_maxBid;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_REPORT;
          end else if (r_to == TW'(ROUND_TIMEOUT)) begin
            r_rsp_kind    <= 1'b1;
            r_rsp_err     <= '0;
            r_rsp_win     <= '0;
            r_rsp_maxbid  <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= ST_REPORT;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        ST_REPORT: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Controller port decode: Lock is held through the wait so the controller
  // answers with duplicate-bid/no-error rather than invalid-op.
  always_comb begin
    C_op    = OP_NOP;
    C_data  = '0;
    C_start = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        C_op   = r_op;
        C_data = r_data;
      end
      ST_ROUND: begin
        C_op    = OP_LOCK;
        C_start = 1'b1;
      end
      ST_WAIT:  C_op = OP_LOCK;
      default: ;
    endcase
  end

  assign rsp_valid   = (r_state == ST_REPORT);
  assign rsp_kind    = r_rsp_kind;
  assign rsp_err     = r_rsp_err;
  assign rsp_win     = r_rsp_win;
  assign rsp_maxbid  = r_rsp_maxbid;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = (r_state != ST_IDLE);
  assign fifo_count  = r_count;

endmodule

// File: tb/tb_bids_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bids_ctrl_sequencer
//   Self-checking bench: expected responses are queued when commands are
//   pushed and compared by a monitor whenever rsp_valid is seen. Controller
//   behaviour is modelled by the bench (err either forced or taken from
//   C_data[2:0] so response order is visible).
// -----------------------------------------------------------------------------
module tb_bids_ctrl_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 64;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_kind = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic [3:0]  C_op;
  logic [31:0] C_data;
  logic        C_start;
  logic        ctrl_ready = 1'b1;
  logic [2:0]  ctrl_err;
  logic        ctrl_roundOver = 1'b0;
  logic [2:0]  ctrl_win = '0;
  logic [31:0] ctrl_maxBid = '0;
  logic        rsp_valid;
  logic        rsp_kind;
  logic [2:0]  rsp_err;
  logic [2:0]  rsp_win;
  logic [31:0] rsp_maxbid;
  logic        rsp_timeout;
  logic        busy;
  logic [$clog2(DEPTH):0] fifo_count;

  logic        use_data_err = 1'b0;
  logic [2:0]  err_force = '0;

  assign ctrl_err = use_data_err ? C_data[2:0] : err_force;

  bids_ctrl_sequencer #(.FIFO_DEPTH(DEPTH), .ROUND_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .C_op(C_op), .C_data(C_data), .C_start(C_start),
    .ctrl_ready(ctrl_ready), .ctrl_err(ctrl_err),
    .ctrl_roundOver(ctrl_roundOver), .ctrl_win(ctrl_win),
    .ctrl_maxBid(ctrl_maxBid),
    .rsp_valid(rsp_valid), .rsp_kind(rsp_kind), .rsp_err(rsp_err),
    .rsp_win(rsp_win), .rsp_maxbid(rsp_maxbid), .rsp_timeout(rsp_timeout),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        kind;
    logic [2:0]  err;
    logic [2:0]  win;
    logic [31:0] maxbid;
    logic        timeout;
  } rsp_t;

  rsp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic rsp_t mk_rsp(input logic k, input logic [2:0] e,
                                  input logic [2:0] w, input logic [31:0] m,
                                  input logic t);
    rsp_t r;
    r.kind = k; r.err = e; r.win = w; r.maxbid = m; r.timeout = t;
    return r;
  endfunction

  // Response monitor / scoreboard consumer
  always @(negedge clk) begin : mon
    rsp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_val("rsp_kind",    64'(rsp_kind),    64'(e.kind));
        check_val("rsp_err",     64'(rsp_err),     64'(e.err));
        check_val("rsp_win",     64'(rsp_win),     64'(e.win));
        check_val("rsp_maxbid",  64'(rsp_maxbid),  64'(e.maxbid));
        check_val("rsp_timeout", 64'(rsp_timeout), 64'(e.timeout));
      end
    end
  end

  // Called just after a negedge; returns one negedge later
  task automatic push(input logic k, input logic [3:0] op, input logic [31:0] d);
    cmd_valid = 1'b1; cmd_kind = k; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic issue_op(input logic [3:0] op, input logic [31:0] d,
                          input logic [2:0] e);
    err_force = e;
    exp_q.push_back(mk_rsp(1'b0, e, 3'b000, 32'd0, 1'b0));
    push(1'b0, op, d);
    @(negedge clk);
    check_val("issue_op",    64'(C_op),    64'(op));
    check_val("issue_data",  64'(C_data),  64'(d));
    check_val("issue_start", 64'(C_start), 64'(0));
    @(negedge clk);
    check_val("post_op",     64'(C_op),      64'(0));
    check_val("post_data",   64'(C_data),    64'(0));
    check_val("op_rsp_lat",  64'(rsp_valid), 64'(1));
    @(negedge clk);
    check_val("op_idle",     64'(busy),      64'(0));
    err_force = '0;
  endtask

  task automatic run_round(input logic [31:0] d, input int unsigned exp_hi,
                           input logic respond);
    int unsigned hi;
    int unsigned w;
    logic        op_ok;
    if (respond) exp_q.push_back(mk_rsp(1'b1, err_force, ctrl_win, ctrl_maxBid, 1'b0));
    else         exp_q.push_back(mk_rsp(1'b1, 3'b000, 3'b000, 32'd0, 1'b1));
    push(1'b1, 4'd0, d);
    @(negedge clk);
    check_val("round_rise", 64'(C_start), 64'(1));
    hi = 0;
    op_ok = 1'b1;
    while (C_start === 1'b1 && hi < 100) begin
      hi++;
      if (C_op !== 4'd2 || C_data !== 32'd0) op_ok = 1'b0;
      @(negedge clk);
    end
    check_val("round_len",   64'(hi),     64'(exp_hi));
    check_val("round_lock",  64'(op_ok),  64'(1));
    check_val("wait_lock",   64'(C_op),   64'(2));
    if (respond) begin
      @(negedge clk);
      ctrl_roundOver = 1'b1;
      @(negedge clk);
      ctrl_roundOver = 1'b0;
      check_val("round_rsp_lat", 64'(rsp_valid), 64'(1));
    end else begin
      w = 0;
      while (rsp_valid !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      check_val("timeout_lat", 64'(w), 64'(TMO + 1));
    end
    @(negedge clk);
    check_val("round_idle", 64'(busy), 64'(0));
    check_val("round_nop",  64'(C_op), 64'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int unsigned w;
    // Power-on reset
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_cmd_ready", 64'(cmd_ready),  64'(0));
    check_val("rst_start",     64'(C_start),    64'(0));
    check_val("rst_op",        64'(C_op),       64'(0));
    check_val("rst_busy",      64'(busy),       64'(0));
    check_val("rst_count",     64'(fifo_count), 64'(0));
    check_val("rst_rsp",       64'(rsp_valid),  64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rel_cmd_ready", 64'(cmd_ready), 64'(1));

    // Reset in the middle of a round with one command still queued
    push(1'b1, 4'd0, 32'd20);
    push(1'b0, 4'd7, 32'd1);
    check_val("mid_start", 64'(C_start),    64'(1));
    check_val("pushpop",   64'(fifo_count), 64'(1));
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_start", 64'(C_start),    64'(0));
    check_val("mid_rst_count", 64'(fifo_count), 64'(0));
    check_val("mid_rst_ready", 64'(cmd_ready),  64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("mid_rel_ready", 64'(cmd_ready), 64'(1));
    repeat (4) @(negedge clk);
    check_val("mid_rel_busy", 64'(busy), 64'(0));

    // Single ops
    issue_op(4'd3,  32'h64,        3'b000);
    issue_op(4'd1,  32'h0,         3'b001);
    issue_op(4'd15, 32'hFFFF_FFFF, 3'b000);

    // Rounds answered one cycle after C_start drops
    err_force = 3'b000; ctrl_win = 3'b100; ctrl_maxBid = 32'h30;
    run_round(32'd5, 5, 1'b1);
    run_round(32'd0, 1, 1'b1);
    ctrl_win = 3'b010; ctrl_maxBid = 32'h77;
    run_round(32'hABCD_0003, 3, 1'b1);

    // Round with no roundOver: timeout
    err_force = 3'b010; ctrl_win = 3'b111; ctrl_maxBid = 32'hDEAD;
    run_round(32'd2, 2, 1'b0);
    err_force = 3'b000; ctrl_win = '0; ctrl_maxBid = '0;

    // Fill the queue while the controller is not ready
    ctrl_ready = 1'b0;
    use_data_err = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("fill_ready", 64'(cmd_ready), 64'(1));
      exp_q.push_back(mk_rsp(1'b0, 3'(i + 1), 3'b000, 32'd0, 1'b0));
      push(1'b0, 4'(9 + i), 32'(i + 1));
    end
    check_val("full_count", 64'(fifo_count), 64'(DEPTH));
    check_val("full_ready", 64'(cmd_ready),  64'(0));
    push(1'b0, 4'd13, 32'd5);
    check_val("drop_count", 64'(fifo_count), 64'(DEPTH));
    repeat (3) @(negedge clk);
    check_val("hold_busy",  64'(busy),       64'(0));
    check_val("hold_count", 64'(fifo_count), 64'(DEPTH));
    ctrl_ready = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || busy === 1'b1) && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    check_val("drain_q",     64'(exp_q.size()), 64'(0));
    check_val("drain_count", 64'(fifo_count),   64'(0));
    use_data_err = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
